// File: rtl/dds_pkg.sv
// dds_pkg: definitions shared across the DDS_Top front-end blocks.
//   btn_state_t   - debounce FSM states for the push-button receiver
//   WAVE_*        - waveform index codes used by the phase-to-amplitude stage
//   NUM_WAVES     - number of selectable waveforms
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int WAVE_SINE     = 0;
    localparam int WAVE_SQUARE   = 1;
    localparam int WAVE_TRIANGLE = 2;
    localparam int WAVE_SAW      = 3;

    localparam int NUM_WAVES = 4;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
//   clk_sys - destination clock
//   rst_b   - asynchronous active-low reset; both flops load RST_VAL
//   d       - asynchronous input
//   q       - synchronised output, two clk_sys edges behind d
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_wave_sel.sv
// btn_wave_sel: push-button receiver for DDS_Top.
//   CLK        - system clock
//   RESETn     - asynchronous active-low reset
//   iExtBtn    - raw button pin, 0 = pressed, asynchronous to CLK
//   oBtnLevel  - debounced level, 1 = released
//   oPress     - one-cycle pulse per accepted press
//   oLongPress - one-cycle pulse when a hold reaches LONG_CYCLES
//   oWaveSel   - waveform index, advances on press, returns to sine on long press
//
// state        | meaning
// IDLE         | released and stable, waiting for a low sample
// PRESS_WAIT   | low seen, counting stable low samples
// PRESSED      | press accepted, counting hold time
// RELEASE_WAIT | high seen, counting stable high samples
module btn_wave_sel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 2500000,
    parameter int NUM_WAVES       = dds_pkg::NUM_WAVES,
    parameter int SEL_W           = 2
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             iExtBtn,
    output logic             oBtnLevel,
    output logic             oPress,
    output logic             oLongPress,
    output logic [SEL_W-1:0] oWaveSel
);

    import dds_pkg::*;

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_WAVES - 1);
    localparam logic [SEL_W-1:0]  SEL_DEF   = SEL_W'(WAVE_SINE);

    logic btn_s;

    btn_state_t        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [HOLD_W-1:0] hold, hold_d;
    logic              press_d, long_d, level_d;
    logic [SEL_W-1:0]  sel_d;

    // Idles released so a reset never looks like a press edge.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_sys (CLK),
        .rst_b   (RESETn),
        .d       (iExtBtn),
        .q       (btn_s)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= IDLE;
            cnt        <= '0;
            hold       <= '0;
            oPress     <= 1'b0;
            oLongPress <= 1'b0;
            oBtnLevel  <= 1'b1;
            oWaveSel   <= SEL_DEF;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            hold       <= hold_d;
            oPress     <= press_d;
            oLongPress <= long_d;
            oBtnLevel  <= level_d;
            oWaveSel   <= sel_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        hold_d  = hold;
        press_d = 1'b0;
        long_d  = 1'b0;

        case (state)
            IDLE: begin
                if (!btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (btn_s) begin
                    state_d = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_d = PRESSED;
                    hold_d  = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                // Saturating one past the fire point makes the long pulse one-shot.
                if (hold != HOLD_SAT) begin
                    hold_d = hold + HOLD_W'(1);
                end
                if (hold == HOLD_LAST) begin
                    long_d = 1'b1;
                end
                if (btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // Bounce back to PRESSED keeps the hold count running.
                if (!btn_s) begin
                    state_d = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase

        level_d = !((state_d == PRESSED) || (state_d == RELEASE_WAIT));

        if (long_d) begin
            sel_d = SEL_DEF;
        end else if (press_d) begin
            sel_d = (oWaveSel == SEL_LAST) ? '0 : oWaveSel + SEL_W'(1);
        end else begin
            sel_d = oWaveSel;
        end
    end

endmodule

// File: tb/tb_btn_wave_sel.sv
// tb_btn_wave_sel: scoreboard bench for btn_wave_sel.
// Stimulus pushes expected pulses (kind, wave index, cycle); a monitor pops
// one entry per observed oPress/oLongPress pulse and compares.
module tb_btn_wave_sel;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic       iExtBtn;
    logic       oBtnLevel;
    logic       oPress;
    logic       oLongPress;
    logic [1:0] oWaveSel;

    btn_wave_sel #(
        .DEBOUNCE_CYCLES (16),
        .LONG_CYCLES     (64),
        .NUM_WAVES       (4),
        .SEL_W           (2)
    ) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .iExtBtn    (iExtBtn),
        .oBtnLevel  (oBtnLevel),
        .oPress     (oPress),
        .oLongPress (oLongPress),
        .oWaveSel   (oWaveSel)
    );

    always #10 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         is_long;
        logic [1:0] sel;
        int         at;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] exp_sel;

    // Cycle offsets from the drive point (edge 1 = first edge sampling low).
    localparam int PRESS_AT = 19;
    localparam int LONG_AT  = 83;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic expect_pulse(input bit is_long, input logic [1:0] sel, input int at);
        exp_t e;
        e.is_long = is_long;
        e.sel     = sel;
        e.at      = at;
        sb.push_back(e);
    endtask

    // Drive the button low for low_n sampling edges, then high for gap_n.
    task automatic press(input int low_n, input int gap_n);
        int t0;
        bit accepted;
        @(negedge CLK);
        iExtBtn  = 1'b0;
        t0       = cyc;
        accepted = (low_n >= 17);
        if (accepted) begin
            exp_sel = (exp_sel == 2'd3) ? 2'd0 : exp_sel + 2'd1;
            expect_pulse(1'b0, exp_sel, t0 + PRESS_AT);
        end
        if (low_n >= 82) begin
            exp_sel = 2'd0;
            expect_pulse(1'b1, 2'd0, t0 + LONG_AT);
        end
        for (int i = 1; i <= low_n; i++) begin
            @(negedge CLK);
            if (accepted && i == 21) check("held_level", oBtnLevel, 0);
        end
        if (!accepted) check("glitch_level", oBtnLevel, 1);
        iExtBtn = 1'b1;
        repeat (gap_n) @(negedge CLK);
        check("released_level", oBtnLevel, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (oPress === 1'b1 || oLongPress === 1'b1) begin
                checks++;
                if (oPress === 1'b1 && oLongPress === 1'b1) begin
                    errors++;
                    $display("FAIL pulse_overlap: press=1 long=1 at cycle %0d, required at most one", cyc);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: press=%0b long=%0b sel=%0d at cycle %0d, expected none",
                             oPress, oLongPress, oWaveSel, cyc);
                end else begin
                    e = sb.pop_front();
                    if (oLongPress !== e.is_long || oWaveSel !== e.sel || cyc != e.at) begin
                        errors++;
                        $display("FAIL pulse: got long=%0b sel=%0d cycle=%0d expected long=%0b sel=%0d cycle=%0d",
                                 oLongPress, oWaveSel, cyc, e.is_long, e.sel, e.at);
                    end
                end
            end
        end
    end

    initial begin : stim
        int t0;
        int t1;
        RESETn  = 1'b0;
        iExtBtn = 1'b1;
        exp_sel = 2'd0;
        repeat (3) @(negedge CLK);
        check("rst_level", oBtnLevel, 1);
        check("rst_press", oPress, 0);
        check("rst_long", oLongPress, 0);
        check("rst_sel", oWaveSel, 0);
        RESETn = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_level", oBtnLevel, 1);

        // clean press
        press(25, 30);
        check("clean_sel", oWaveSel, 1);

        // glitch shorter than debounce window
        press(10, 30);
        check("glitch_sel", oWaveSel, 1);

        // wrap through all four indices: 2,3,0,1
        repeat (4) press(25, 30);
        check("wrap_sel", oWaveSel, 1);

        // release bounce: three low spikes inside the release window
        @(negedge CLK);
        iExtBtn = 1'b0;
        t0      = cyc;
        exp_sel = 2'd2;
        expect_pulse(1'b0, 2'd2, t0 + PRESS_AT);
        repeat (25) @(negedge CLK);
        iExtBtn = 1'b1;
        repeat (3) begin
            repeat (3) @(negedge CLK);
            iExtBtn = 1'b0;
            repeat (5) @(negedge CLK);
            iExtBtn = 1'b1;
        end
        repeat (30) @(negedge CLK);
        check("bounce_level", oBtnLevel, 1);
        check("bounce_sel", oWaveSel, 2);

        // long hold from index 2: press -> 3, long -> 0, no repeat
        press(100, 30);
        check("long_sel", oWaveSel, 0);

        // reset while held in PRESSED at index 2
        press(25, 30);
        @(negedge CLK);
        iExtBtn = 1'b0;
        t0      = cyc;
        exp_sel = 2'd2;
        expect_pulse(1'b0, 2'd2, t0 + PRESS_AT);
        repeat (30) @(negedge CLK);
        check("pre_reset_level", oBtnLevel, 0);
        check("pre_reset_sel", oWaveSel, 2);
        RESETn = 1'b0;
        #1;
        check("mid_rst_level", oBtnLevel, 1);
        check("mid_rst_press", oPress, 0);
        check("mid_rst_long", oLongPress, 0);
        check("mid_rst_sel", oWaveSel, 0);
        #4;
        RESETn  = 1'b1;
        t1      = cyc;
        exp_sel = 2'd1;
        expect_pulse(1'b0, 2'd1, t1 + PRESS_AT);
        repeat (40) @(negedge CLK);
        check("requal_level", oBtnLevel, 0);
        iExtBtn = 1'b1;
        repeat (30) @(negedge CLK);
        check("requal_released", oBtnLevel, 1);
        check("requal_sel", oWaveSel, 1);

        repeat (5) @(negedge CLK);
        check("missing_pulses", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
